// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Decode-side producer for the EX ALU op interface. Takes one RV32I instruction
// plus its register operands per valid/ready handshake and decodes it into an
// ALU function code and two operands. The decoded op sits in an output register
// until EX consumes it, or until a flush kills it.
//
// Function codes:
//   0 add | 1 sub | 2 eq | 3 ltu | 4 lt | 5 and | 6 or | 7 xor
//   8 srl | 9 sll | 10 pass src2 | 11 sra
//
// Branches are decoded into a compare op. br_inv marks the branches that are
// taken when the ALU result is 0 (BNE/BGE/BGEU). Unsupported encodings still
// occupy a slot, so EX can raise the exception in program order. Such a slot
// carries illegal=1 and zero operands, and never writes rd.
module alu_issue_stage #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_func,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [4:0]       rd,
    output logic             rd_we,
    output logic             br_inv,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_EQ   = 4'd2;
    localparam logic [3:0] FN_LTU  = 4'd3;
    localparam logic [3:0] FN_LT   = 4'd4;
    localparam logic [3:0] FN_AND  = 4'd5;
    localparam logic [3:0] FN_OR   = 4'd6;
    localparam logic [3:0] FN_XOR  = 4'd7;
    localparam logic [3:0] FN_SRL  = 4'd8;
    localparam logic [3:0] FN_SLL  = 4'd9;
    localparam logic [3:0] FN_PASS = 4'd10;
    localparam logic [3:0] FN_SRA  = 4'd11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Instruction fields
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd_field;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt_imm;
    logic [31:0] w_shamt_reg;

    assign w_opc       = inst[6:0];
    assign w_f3        = inst[14:12];
    assign w_f7        = inst[31:25];
    assign w_rd_field  = inst[11:7];
    assign w_imm_i     = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_u     = {inst[31:12], 12'b0};
    assign w_shamt_imm = {27'b0, inst[24:20]};
    assign w_shamt_reg = {27'b0, rs2_data[4:0]};

    // Decoded op, before it is registered
    logic [3:0]  w_func;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [4:0]  w_rd;
    logic        w_writes;
    logic        w_inv;
    logic        w_ill;
    logic        w_rd_we;

    // Handshake
    logic w_xfer_in;
    logic w_consume;

    // Output register
    logic             r_valid;
    logic [3:0]       r_func;
    logic [31:0]      r_src1;
    logic [31:0]      r_src2;
    logic [4:0]       r_rd;
    logic             r_rd_we;
    logic             r_inv;
    logic             r_ill;
    logic [CNT_W-1:0] r_cnt;

    // Decode the offered instruction into ALU function, operands and writeback info
    always_comb begin
        w_func   = FN_ADD;
        w_src1   = 32'b0;
        w_src2   = 32'b0;
        w_rd     = 5'b0;
        w_writes = 1'b0;
        w_inv    = 1'b0;
        w_ill    = 1'b0;

        case (w_opc)
            OPC_OP: begin
                w_src1   = rs1_data;
                w_src2   = rs2_data;
                w_rd     = w_rd_field;
                w_writes = 1'b1;
                case (w_f3)
                    3'b000: begin
                        if (w_f7 == F7_BASE)     w_func = FN_ADD;
                        else if (w_f7 == F7_ALT) w_func = FN_SUB;
                        else                     w_ill  = 1'b1;
                    end
                    3'b001: begin
                        w_func = FN_SLL;
                        w_src2 = w_shamt_reg;
                        w_ill  = (w_f7 != F7_BASE);
                    end
                    3'b010: begin
                        w_func = FN_LT;
                        w_ill  = (w_f7 != F7_BASE);
                    end
                    3'b011: begin
                        w_func = FN_LTU;
                        w_ill  = (w_f7 != F7_BASE);
                    end
                    3'b100: begin
                        w_func = FN_XOR;
                        w_ill  = (w_f7 != F7_BASE);
                    end
                    3'b101: begin
                        w_src2 = w_shamt_reg;
                        if (w_f7 == F7_BASE)     w_func = FN_SRL;
                        else if (w_f7 == F7_ALT) w_func = FN_SRA;
                        else                     w_ill  = 1'b1;
                    end
                    3'b110: begin
                        w_func = FN_OR;
                        w_ill  = (w_f7 != F7_BASE);
                    end
                    default: begin
                        w_func = FN_AND;
                        w_ill  = (w_f7 != F7_BASE);
                    end
                endcase
            end

            OPC_OP_IMM: begin
                w_src1   = rs1_data;
                w_src2   = w_imm_i;
                w_rd     = w_rd_field;
                w_writes = 1'b1;
                case (w_f3)
                    3'b000: w_func = FN_ADD;
                    3'b001: begin
                        w_func = FN_SLL;
                        w_src2 = w_shamt_imm;
                        w_ill  = (w_f7 != F7_BASE);
                    end
                    3'b010: w_func = FN_LT;
                    3'b011: w_func = FN_LTU;
                    3'b100: w_func = FN_XOR;
                    3'b101: begin
                        // inst[30] picks SRAI; every other funct7 bit must be clear
                        w_src2 = w_shamt_imm;
                        if (w_f7 == F7_BASE)     w_func = FN_SRL;
                        else if (w_f7 == F7_ALT) w_func = FN_SRA;
                        else                     w_ill  = 1'b1;
                    end
                    3'b110: w_func = FN_OR;
                    default: w_func = FN_AND;
                endcase
            end

            OPC_LUI: begin
                w_func   = FN_PASS;
                w_src2   = w_imm_u;
                w_rd     = w_rd_field;
                w_writes = 1'b1;
            end

            OPC_AUIPC: begin
                w_func   = FN_ADD;
                w_src1   = pc;
                w_src2   = w_imm_u;
                w_rd     = w_rd_field;
                w_writes = 1'b1;
            end

            OPC_JAL: begin
                // ALU produces the link value; the target is computed elsewhere
                w_func   = FN_ADD;
                w_src1   = pc;
                w_src2   = 32'd4;
                w_rd     = w_rd_field;
                w_writes = 1'b1;
            end

            OPC_JALR: begin
                w_func   = FN_ADD;
                w_src1   = pc;
                w_src2   = 32'd4;
                w_rd     = w_rd_field;
                w_writes = 1'b1;
                w_ill    = (w_f3 != 3'b000);
            end

            OPC_LOAD: begin
                w_func   = FN_ADD;
                w_src1   = rs1_data;
                w_src2   = w_imm_i;
                w_rd     = w_rd_field;
                w_writes = 1'b1;
                w_ill    = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end

            OPC_STORE: begin
                w_func = FN_ADD;
                w_src1 = rs1_data;
                w_src2 = w_imm_s;
                w_ill  = w_f3[2] || (w_f3 == 3'b011);
            end

            OPC_BRANCH: begin
                w_src1 = rs1_data;
                w_src2 = rs2_data;
                w_inv  = w_f3[0];
                case (w_f3[2:1])
                    2'b00:   w_func = FN_EQ;
                    2'b10:   w_func = FN_LT;
                    2'b11:   w_func = FN_LTU;
                    default: w_ill  = 1'b1;
                endcase
            end

            default: w_ill = 1'b1;
        endcase

        // An illegal slot carries no operands and no writeback
        if (w_ill) begin
            w_func   = FN_ADD;
            w_src1   = 32'b0;
            w_src2   = 32'b0;
            w_rd     = 5'b0;
            w_writes = 1'b0;
            w_inv    = 1'b0;
        end
    end

    assign w_rd_we   = w_writes && (w_rd != 5'd0);

    assign in_ready  = !r_valid || out_ready;
    assign w_xfer_in = in_valid && in_ready && !flush;
    assign w_consume = r_valid && out_ready && !flush;

    // Output register: flush kills, accept loads (also back-to-back), consume empties
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_func  <= 4'b0;
            r_src1  <= 32'b0;
            r_src2  <= 32'b0;
            r_rd    <= 5'b0;
            r_rd_we <= 1'b0;
            r_inv   <= 1'b0;
            r_ill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer_in) begin
            r_valid <= 1'b1;
            r_func  <= w_func;
            r_src1  <= w_src1;
            r_src2  <= w_src2;
            r_rd    <= w_rd;
            r_rd_we <= w_rd_we;
            r_inv   <= w_inv;
            r_ill   <= w_ill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Count ops handed to EX; wraps naturally
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_consume) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_valid;
    assign alu_func   = r_func;
    assign alu_src1   = r_src1;
    assign alu_src2   = r_src2;
    assign rd         = r_rd;
    assign rd_we      = r_rd_we;
    assign br_inv     = r_inv;
    assign illegal    = r_ill;
    assign issued_cnt = r_cnt;

endmodule
